// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Pipeline hazard and stall sequencer for the five-stage CPU. Merges load-use
// detection, taken-branch / jump flushes and multi-cycle mul/div occupancy of
// EX into one set of pipeline-register write enables and bubble controls, and
// keeps a saturating count of cycles in which the PC was held.
//
// Parameters:
//   MD_CYCLES      total EX occupancy of a mul/div instruction (2..16)
// Ports:
//   CLK            pipeline clock, rising edge
//   Reset          synchronous, active-high reset
//   EX_MemRead     load in EX
//   EX_rt          destination register of the load in EX
//   ID_rs, ID_rt   source fields of the instruction in ID
//   ID_UseRt       ID instruction reads rt
//   ID_Jump        j/jal/jr in ID
//   EX_BranchTaken branch in EX resolved taken
//   EX_MulDiv      mult/multu/div/divu in EX
//   PCWre          PC write enable
//   IF_ID_Wre      IF/ID write enable
//   IF_ID_Flush    load a NOP into IF/ID
//   ID_EX_Wre      ID/EX write enable
//   ControlSrc     zero the controls entering ID/EX
//   EX_MEM_Bubble  zero the controls entering EX/MEM
//   MD_Start       one-cycle start pulse to the mul/div unit
//   Busy           mul/div occupancy in progress
//   StallCnt       saturating count of cycles with PCWre=0

module hazard_sequencer #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rt,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRt,
  input  logic        ID_Jump,
  input  logic        EX_BranchTaken,
  input  logic        EX_MulDiv,
  output logic        PCWre,
  output logic        IF_ID_Wre,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Wre,
  output logic        ControlSrc,
  output logic        EX_MEM_Bubble,
  output logic        MD_Start,
  output logic        Busy,
  output logic [15:0] StallCnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        load_use;

  // EX_rt==0 is the hard-wired zero register and can never create a hazard.
  assign load_use = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (ID_UseRt && (EX_rt == ID_rt)));

  assign Busy = (state == MD_BUSY) && !Reset;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= RUN;
      cnt      <= '0;
      StallCnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!PCWre && (StallCnt != '1))
        StallCnt <= StallCnt + 16'd1;
    end
  end

  always_comb begin
    PCWre         = 1'b1;
    IF_ID_Wre     = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Wre     = 1'b1;
    ControlSrc    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MD_Start      = 1'b0;
    state_next    = state;
    cnt_next      = cnt;

    if (Reset) begin
      PCWre         = 1'b0;
      IF_ID_Wre     = 1'b0;
      ID_EX_Wre     = 1'b0;
      ControlSrc    = 1'b1;
      IF_ID_Flush   = 1'b1;
      EX_MEM_Bubble = 1'b1;
      state_next    = RUN;
      cnt_next      = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ControlSrc  = 1'b1;
          end else if (EX_MulDiv) begin
            MD_Start      = 1'b1;
            PCWre         = 1'b0;
            IF_ID_Wre     = 1'b0;
            ID_EX_Wre     = 1'b0;
            EX_MEM_Bubble = 1'b1;
            state_next    = MD_BUSY;
            cnt_next      = MD_LOAD;
          end else if (load_use) begin
            PCWre      = 1'b0;
            IF_ID_Wre  = 1'b0;
            ControlSrc = 1'b1;
          end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt > 4'd1) begin
            PCWre         = 1'b0;
            IF_ID_Wre     = 1'b0;
            ID_EX_Wre     = 1'b0;
            EX_MEM_Bubble = 1'b1;
            cnt_next      = cnt - 4'd1;
          end else begin
            // Final cycle: default enables let the result enter EX/MEM.
            state_next = RUN;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        EX_MemRead;
  logic [4:0]  EX_rt;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRt;
  logic        ID_Jump;
  logic        EX_BranchTaken;
  logic        EX_MulDiv;
  logic        PCWre;
  logic        IF_ID_Wre;
  logic        IF_ID_Flush;
  logic        ID_EX_Wre;
  logic        ControlSrc;
  logic        EX_MEM_Bubble;
  logic        MD_Start;
  logic        Busy;
  logic [15:0] StallCnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_stall = '0;

  hazard_sequencer #(.MD_CYCLES(4)) dut (
    .CLK(CLK), .Reset(Reset), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulDiv(EX_MulDiv),
    .PCWre(PCWre), .IF_ID_Wre(IF_ID_Wre), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Wre(ID_EX_Wre), .ControlSrc(ControlSrc),
    .EX_MEM_Bubble(EX_MEM_Bubble), .MD_Start(MD_Start), .Busy(Busy),
    .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and leave inputs safely away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EX_MemRead = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0; ID_UseRt = 0;
    ID_Jump = 0; EX_BranchTaken = 0; EX_MulDiv = 0;
  endtask

  // Packed view of the seven combinational controls:
  // {PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Wre, ControlSrc, EX_MEM_Bubble, MD_Start}
  function automatic logic [6:0] ctl();
    return {PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Wre, ControlSrc, EX_MEM_Bubble, MD_Start};
  endfunction

  task automatic test_reset();
    Reset = 1; idle_inputs();
    tick();
    checks++;
    if (ctl() !== 7'b0010110 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b busy=%b, expected ctl=0010110 busy=0", ctl(), Busy);
    end
    Reset = 0;
    #1;
    checks++;
    if (StallCnt !== 16'd0 || Busy !== 1'b0 || ctl() !== 7'b1101000) begin
      errors++;
      $display("FAIL reset_after: got stall=%0d busy=%b ctl=%b, expected 0 0 1101000", StallCnt, Busy, ctl());
    end
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    // no conflict
    EX_MemRead = 1; EX_rt = 3; ID_rs = 4; ID_rt = 5; ID_UseRt = 1;
    #1;
    checks++;
    if (ctl() !== 7'b1101000) begin
      errors++;
      $display("FAIL lu_no_conflict: got ctl=%b, expected 1101000", ctl());
    end
    tick();
    // rs conflict
    EX_rt = 4; ID_rs = 4;
    #1;
    checks++;
    if (ctl() !== 7'b0001100) begin
      errors++;
      $display("FAIL lu_rs_conflict: got ctl=%b, expected 0001100", ctl());
    end
    tick(); exp_stall++;
    idle_inputs();
    #1;
    checks++;
    if (StallCnt !== exp_stall) begin
      errors++;
      $display("FAIL lu_stallcnt: got %0d, expected %0d", StallCnt, exp_stall);
    end
    // rt match without ID_UseRt
    EX_MemRead = 1; EX_rt = 5; ID_rs = 4; ID_rt = 5; ID_UseRt = 0;
    #1;
    checks++;
    if (PCWre !== 1'b1 || ControlSrc !== 1'b0) begin
      errors++;
      $display("FAIL lu_rt_unused: got PCWre=%b ControlSrc=%b, expected 1 0", PCWre, ControlSrc);
    end
    // rt match with ID_UseRt
    ID_UseRt = 1;
    #1;
    checks++;
    if (PCWre !== 1'b0 || IF_ID_Wre !== 1'b0 || ControlSrc !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_used: got PCWre=%b IF_ID_Wre=%b ControlSrc=%b, expected 0 0 1", PCWre, IF_ID_Wre, ControlSrc);
    end
    tick(); exp_stall++;
    // zero register never stalls
    EX_rt = 0; ID_rs = 0; ID_rt = 0; ID_UseRt = 1;
    #1;
    checks++;
    if (ctl() !== 7'b1101000) begin
      errors++;
      $display("FAIL lu_zero_reg: got ctl=%b, expected 1101000", ctl());
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (StallCnt !== exp_stall) begin
      errors++;
      $display("FAIL lu_stallcnt2: got %0d, expected %0d", StallCnt, exp_stall);
    end
  endtask

  task automatic test_branch_jump();
    EX_BranchTaken = 1; EX_MemRead = 1; EX_rt = 4; ID_rs = 4; ID_Jump = 1; EX_MulDiv = 1;
    #1;
    checks++;
    if (ctl() !== 7'b1111100 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_priority: got ctl=%b busy=%b, expected 1111100 0", ctl(), Busy);
    end
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_no_md: got busy=%b, expected 0", Busy);
    end
    idle_inputs();
    ID_Jump = 1;
    #1;
    checks++;
    if (ctl() !== 7'b1111000) begin
      errors++;
      $display("FAIL jump_alone: got ctl=%b, expected 1111000", ctl());
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_muldiv();
    int unsigned starts = 0;
    EX_MulDiv = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0000011 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL md_entry: got ctl=%b busy=%b, expected 0000011 0", ctl(), Busy);
    end
    if (MD_Start) starts++;
    tick();
    for (int i = 1; i <= 3; i++) begin
      // branch in EX must be ignored while the mul/div owns EX
      EX_BranchTaken = (i == 1);
      #1;
      checks++;
      if (i < 3) begin
        if (ctl() !== 7'b0000010 || Busy !== 1'b1) begin
          errors++;
          $display("FAIL md_busy_%0d: got ctl=%b busy=%b, expected 0000010 1", i, ctl(), Busy);
        end
      end else begin
        if (ctl() !== 7'b1101000 || Busy !== 1'b1) begin
          errors++;
          $display("FAIL md_final: got ctl=%b busy=%b, expected 1101000 1", ctl(), Busy);
        end
      end
      if (MD_Start) starts++;
      tick();
    end
    idle_inputs();
    exp_stall += 3;
    #1;
    checks++;
    if (Busy !== 1'b0 || starts != 1 || StallCnt !== exp_stall) begin
      errors++;
      $display("FAIL md_done: got busy=%b starts=%0d stall=%0d, expected 0 1 %0d", Busy, starts, StallCnt, exp_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pulses = '0;
    EX_MulDiv = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      pulses[i] = MD_Start;
      if (MD_Start && Busy) begin
        checks++;
        errors++;
        $display("FAIL b2b_start_while_busy: got MD_Start=1 Busy=1 at cycle %0d, expected never", i);
      end
      tick();
    end
    idle_inputs();
    exp_stall += 6;
    #1;
    checks++;
    if (pulses !== 8'b0001_0001) begin
      errors++;
      $display("FAIL b2b_pulses: got %b, expected 00010001", pulses);
    end
    checks++;
    if (StallCnt !== exp_stall || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: got stall=%0d busy=%b, expected %0d 0", StallCnt, Busy, exp_stall);
    end
  endtask

  task automatic test_reset_mid_busy();
    int unsigned starts = 0;
    EX_MulDiv = 1;
    tick();          // entry edge, cnt=3
    EX_MulDiv = 0;
    tick();          // cnt=2
    Reset = 1;
    #1;
    checks++;
    if (ctl() !== 7'b0010110 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_outputs: got ctl=%b busy=%b, expected 0010110 0", ctl(), Busy);
    end
    tick();
    Reset = 0;
    #1;
    checks++;
    if (StallCnt !== 16'd0 || Busy !== 1'b0 || ctl() !== 7'b1101000) begin
      errors++;
      $display("FAIL rst_busy_after: got stall=%0d busy=%b ctl=%b, expected 0 0 1101000", StallCnt, Busy, ctl());
    end
    exp_stall = 0;
    for (int i = 0; i < 5; i++) begin
      if (MD_Start) starts++;
      tick();
    end
    checks++;
    if (starts != 0 || StallCnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_busy_quiet: got starts=%0d stall=%0d, expected 0 0", starts, StallCnt);
    end
  endtask

  task automatic test_saturation();
    EX_MemRead = 1; EX_rt = 7; ID_rs = 7;
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (StallCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h, expected ffff", StallCnt);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (StallCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h, expected ffff", StallCnt);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_busy();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the five-stage pipelined CPU. It combines load-use detection, taken-branch and jump flushes, and multi-cycle multiply/divide occupancy of EX into a single set of pipeline-register write enables and bubble/flush controls. It sits beside the ID and EX stages, drives the PC, IF/ID, ID/EX and EX/MEM control inputs, and keeps a saturating stall-cycle counter for performance checks.

## Interface
- MD_CYCLES, 4, total EX occupancy in cycles of a mul/div instruction; legal range 2..16
- CLK  in  1  pipeline clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- EX_MemRead  in  1  instruction in EX is a load
- EX_rt  in  5  destination register of the load in EX
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_UseRt  in  1  instruction in ID reads rt as a source
- ID_Jump  in  1  instruction in ID is j/jal/jr; target resolved in ID
- EX_BranchTaken  in  1  branch in EX resolved taken
- EX_MulDiv  in  1  instruction in EX is mult/multu/div/divu
- PCWre  out  1  PC write enable
- IF_ID_Wre  out  1  IF/ID write enable
- IF_ID_Flush  out  1  load a NOP into IF/ID at next edge
- ID_EX_Wre  out  1  ID/EX write enable (0 holds EX instruction)
- ControlSrc  out  1  1 = zero control signals entering ID/EX (bubble)
- EX_MEM_Bubble  out  1  1 = zero control signals entering EX/MEM
- MD_Start  out  1  one-cycle start pulse to the mul/div unit
- Busy  out  1  state is MD_BUSY
- StallCnt  out  16  count of cycles with PCWre=0, saturating

## Operation
- States: RUN, MD_BUSY. 4-bit down-counter cnt.
- Load-use hazard LU = EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_UseRt && EX_rt==ID_rt)).
- Defaults (RUN, no event): PCWre=1, IF_ID_Wre=1, ID_EX_Wre=1, all others 0.
- RUN priority, highest first:
  - EX_BranchTaken: PCWre=1, IF_ID_Flush=1, ControlSrc=1; LU and ID_Jump ignored.
  - EX_MulDiv: MD_Start=1, PCWre=0, IF_ID_Wre=0, ID_EX_Wre=0, EX_MEM_Bubble=1; next state MD_BUSY, cnt<=MD_CYCLES-1.
  - LU: PCWre=0, IF_ID_Wre=0, ControlSrc=1 (one bubble; the stalled instruction is re-evaluated next cycle).
  - ID_Jump: PCWre=1, IF_ID_Flush=1.
- MD_BUSY, cnt>1: same stall outputs as the mul/div entry cycle, but MD_Start=0; cnt<=cnt-1. EX_BranchTaken, LU and ID_Jump are ignored.
- MD_BUSY, cnt==1 (final cycle): default outputs; the result is written to EX/MEM; next state RUN.
- StallCnt increments by 1 on each edge where PCWre==0 and Reset==0. It holds at 16'hFFFF.

## Timing
- All hazard outputs are combinational from the inputs and state in the same cycle. StallCnt, state and cnt are registered.
- While Reset=1: PCWre=0, IF_ID_Wre=0, ID_EX_Wre=0, ControlSrc=1, IF_ID_Flush=1, EX_MEM_Bubble=1, MD_Start=0, Busy=0.
- After the reset edge: state=RUN, cnt=0, StallCnt=0.
- Reset during MD_BUSY aborts the operation; state is RUN at the next edge.
- A mul/div holds EX for exactly MD_CYCLES cycles: 1 entry cycle plus MD_CYCLES-1 cycles in MD_BUSY. The upstream stall lasts MD_CYCLES-1 cycles.
- MD_Start is high for exactly one cycle per mul/div, and never while Busy=1.
- Back-to-back mul/div: the second one is detected in RUN on the cycle after the final cycle of the first, and gets a fresh MD_Start.
- Load-use stall is exactly 1 cycle. The load has moved to MEM by the next cycle, so LU is false then.
- EX_rt==0 never stalls.

## Test plan
- Load-use, no conflict: EX_MemRead=1, EX_rt=3, ID_rs=4, ID_rt=5 -> PCWre=1, IF_ID_Wre=1, ControlSrc=0.
- Load-use conflict: EX_MemRead=1, EX_rt=4, ID_rs=4 -> PCWre=0, IF_ID_Wre=0, ControlSrc=1, StallCnt +1. Repeat with EX_rt=5=ID_rt, ID_UseRt=0 -> no stall. Repeat with EX_rt=0=ID_rs -> no stall.
- Branch beats load-use: EX_BranchTaken=1, EX_MemRead=1, EX_rt=ID_rs=4 -> PCWre=1, IF_ID_Flush=1, ControlSrc=1. Separately, ID_Jump=1 alone -> IF_ID_Flush=1, ControlSrc=0.
- Mul/div, MD_CYCLES=4: EX_MulDiv=1 in RUN -> MD_Start pulses once, Busy=1 for 3 cycles, PCWre=0 for 3 cycles, PCWre=1 on the 4th cycle, then RUN; StallCnt=3. Back-to-back mul/div -> two MD_Start pulses 4 cycles apart.
- Reset mid-MD_BUSY (cnt=2) -> all outputs at their reset values during Reset; state RUN, StallCnt=0 after the edge; no further MD_Start.
- Saturation: force 70000 stall cycles -> StallCnt=16'hFFFF and holds there.
